soc_run_ctrl: RTL

//  Parametrised reset sequencer and run monitor wrapped around the SOC core. Holds core in reset for a

---
 rtl/run_ctrl_pkg.sv | 23 ++
 rtl/sat_counter.sv | 22 ++
 rtl/soc_run_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the SOC run controller: state encoding, enable
// levels and a counter-width helper.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((max_val >> w) != 0)) w++;
    return w;
  endfunction

endpackage : run_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (count enable),
//        cnt (registered count, sticks at all-ones).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/soc_run_ctrl.sv
// Reset sequencer and run monitor for the SOC core.
// Holds the core in reset for RST_CYCLES after rst, then counts RUN cycles
// and retired instructions until a halt (halt_req or PC self-loop) or a
// timeout; a halt drains for DRAIN_CYC cycles before DONE.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc, pc_valid    observed fetch PC and its qualifier
//   retire          one instruction retired this cycle
//   halt_req        software halt request
//   core_rst        reset to the core (high in RST_HOLD and DONE)
//   running         state is RUN
//   done, timeout   sticky completion / completion-by-timeout flags
//   cycle_cnt       RUN cycles, saturating
//   retire_cnt      retires seen in RUN and DRAIN, saturating
// Build option: RUN_CTRL_TRACE_EN adds simulation-only transition tracing
// and stops the simulation on DONE entry.
module soc_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYC = 100,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned DRAIN_CYC   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic              retire,
  input  logic              halt_req,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int unsigned HOLD_W  = cnt_w(RST_CYCLES - 1);
  localparam int unsigned DRAIN_W = cnt_w((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam int unsigned LOOP_W  = cnt_w(HALT_REPEAT);

  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(RST_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST   = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [LOOP_W-1:0]  LOOP_MAX     = LOOP_W'(HALT_REPEAT);
  localparam logic [LOOP_W-1:0]  LOOP_HIT     = LOOP_W'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state, state_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [DRAIN_W-1:0]  drain_cnt, drain_n;
  logic [LOOP_W-1:0]   loop_cnt, loop_n;
  logic [ADDR_W-1:0]   last_pc, last_pc_n;
  logic                core_rst_n, running_n, done_n, timeout_n;
  logic                cyc_inc, ret_inc;
  logic                loop_hit;

  // Self-loop halt: this cycle would be the HALT_REPEAT-th match in a row.
  assign loop_hit = pc_valid && (pc == last_pc) && (loop_cnt == LOOP_HIT);

  // State, local counters and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_HOLD;
      hold_cnt  <= '0;
      drain_cnt <= '0;
      loop_cnt  <= '0;
      last_pc   <= '0;
      core_rst  <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      drain_cnt <= drain_n;
      loop_cnt  <= loop_n;
      last_pc   <= last_pc_n;
      core_rst  <= core_rst_n;
      running   <= running_n;
      done      <= done_n;
      timeout   <= timeout_n;
    end
  end

  // Next-state, counter updates and next output values.
  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    drain_n   = drain_cnt;
    loop_n    = loop_cnt;
    last_pc_n = last_pc;
    timeout_n = timeout;
    cyc_inc   = DISABLE;
    ret_inc   = DISABLE;

    case (state)
      RST_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_n = RUN;
        else                       hold_n  = hold_cnt + HOLD_W'(1);
      end
      RUN: begin
        cyc_inc = ENABLE;
        ret_inc = retire;
        if (pc_valid) begin
          last_pc_n = pc;
          if (pc == last_pc) begin
            if (loop_cnt != LOOP_MAX) loop_n = loop_cnt + LOOP_W'(1);
          end else begin
            loop_n = '0;
          end
        end
        // Halt has priority over a coincident timeout.
        if (halt_req || loop_hit) begin
          state_n = (DRAIN_CYC == 0) ? DONE : DRAIN;
          drain_n = '0;
        end else if (cycle_cnt == TIMEOUT_LAST) begin
          state_n   = DONE;
          timeout_n = ENABLE;
        end
      end
      DRAIN: begin
        ret_inc = retire;
        if (drain_cnt == DRAIN_LAST) state_n = DONE;
        else                         drain_n = drain_cnt + DRAIN_W'(1);
      end
      default: begin
      end
    endcase

    core_rst_n = (state_n == RST_HOLD) || (state_n == DONE);
    running_n  = (state_n == RUN);
    done_n     = (state_n == DONE);
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (DISABLE),
    .inc (cyc_inc),
    .cnt (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .clr (DISABLE),
    .inc (ret_inc),
    .cnt (retire_cnt)
  );

`ifdef RUN_CTRL_TRACE_EN
  // Transition trace; reported one cycle late so DONE counters are settled.
  state_t trace_state;
  always @(posedge clk) begin
    trace_state <= state;
    if (!rst && (trace_state != state)) begin
      $display("%0t soc_run_ctrl: %s -> %s", $time, trace_state.name(), state.name());
      if (state == DONE) begin
        $display("%0t soc_run_ctrl: cycles=%0d retired=%0d timeout=%0b last_pc=%h",
                 $time, cycle_cnt, retire_cnt, timeout, last_pc);
        $stop(2);
      end
    end
  end
`else
  // No tracing: the enclosing bench observes done directly.
`endif

endmodule : soc_run_ctrl
